spike_rate_encoder: RTL
=======================

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

Interface
REQ-001 SHALL have parameter WINDOW, default 16, giving timesteps per encoded frame (power of two, 2..256).
REQ-002 SHALL have parameter CNT_W, default 5, giving the spike_count width (clog2(WINDOW)+1).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low (one clock; reset is asynchronous and active-low).
REQ-005 SHALL have port in_valid  input  1  in_value offered this cycle.
REQ-006 SHALL have port in_value  input  8  unsigned intensity to encode.
REQ-007 SHALL have port in_ready  output  1  encoder can take in_value this cycle.
REQ-008 SHALL have port step_en  input  1  timestep strobe; encoding advances only on it.
REQ-009 SHALL have port flush  input  1  synchronous abort of all queued and active work.
REQ-010 SHALL have port spike_out  output  1  encoded spike, a one-cycle pulse that drives a neuron's spike_in.
REQ-011 SHALL have port busy  output  1  high while state is RUN.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when a frame's last timestep completes.
REQ-013 SHALL have port spike_count  output  CNT_W  spikes emitted in the last completed frame.

Function
REQ-014 SHALL hold one pending register (pend_val, pend_v) and one active register (cur_val), plus a 9-bit accumulator acc and a timestep counter step_cnt.
REQ-015 SHALL drive in_ready = !pend_v && !flush (combinational).
REQ-016 SHALL capture in_value into pend_val and set pend_v at an edge where in_valid && in_ready.
REQ-017 SHALL implement states IDLE and RUN. IDLE with pend_v: move pend_val to cur_val, clear pend_v, clear acc, run_cnt and step_cnt, and go to RUN at the next edge. IDLE without pend_v: stay in IDLE.
REQ-018 SHALL, in RUN on step_en, compute sum = acc[7:0] + cur_val (9 bits), register spike_out = sum[8], set acc = sum[7:0], increment step_cnt, and increment run_cnt if sum[8].
REQ-019 SHALL hold spike_out at 0 in every cycle not following a RUN step_en, so pulses are exactly one cycle wide.
REQ-020 SHALL, on the step_en where step_cnt == WINDOW-1:
  - pulse frame_done in the next cycle;
  - load spike_count with the final run_cnt, including this step's spike.
REQ-021 SHALL, at the end of a frame with pend_v set, load the pending value, clear acc, step_cnt and run_cnt, and stay in RUN with no idle cycle; with pend_v clear it SHALL return to IDLE.
REQ-022 SHALL emit exactly floor(WINDOW*in_value/256) spikes per frame.
  - in_value 0: no spikes.
  - in_value 255 with WINDOW 16: 15 spikes.
REQ-023 SHALL ignore step_en in IDLE, and SHALL leave state, acc and step_cnt unchanged in RUN while step_en is low.
REQ-024 SHALL, on flush:
  - clear pend_v, acc, step_cnt, run_cnt and spike_out, and go to IDLE at that edge;
  - take precedence over step_en and over any end-of-frame handling;
  - suppress frame_done;
  - leave spike_count unchanged.
REQ-025 SHALL let step_cnt wrap from WINDOW-1 to 0 with no extra cycle.
REQ-026 SHALL keep busy = (state == RUN) as a registered output.

Reset
REQ-027 SHALL, while rst is low, asynchronously force:
  - state IDLE;
  - pend_v, cur_val, acc, step_cnt and run_cnt to 0;
  - spike_out, frame_done, busy and spike_count to 0.
REQ-028 SHALL drive in_ready to 1 under reset when flush is low (a reset mid-frame abandons the frame silently).
REQ-029 SHALL leave reset release synchronous to clk, with the first accept possible at the first rising edge after rst goes high.

Verification
REQ-030 SHALL pass this case: WINDOW 16, in_value 128, step_en every cycle. Required: busy 2 cycles after accept; spikes on steps 1,3,...,15 (8 in total); frame_done once; spike_count 8.
REQ-031 SHALL pass this case: in_value 64, step_en every 3rd cycle. Required: spikes only on steps 3,7,11,15; each pulse one cycle; spike_count 4.
REQ-032 SHALL pass this case: in_value 0, then 255 offered back-to-back. Required: frame 1 spike_count 0; frame 2 starts with no IDLE cycle; frame 2 spike_count 15; in_ready low while both registers are full.
REQ-033 SHALL pass this case: flush asserted mid-frame at step 7 together with in_valid. Required: in_ready 0 that cycle; IDLE next cycle; no frame_done; spike_count keeps its previous value.
REQ-034 SHALL pass this case: rst driven low asynchronously mid-frame while spike_out is high. Required: spike_out, busy and spike_count read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/spike_rate_encoder.sv
`timescale 1ns/1ps
// Rate-coded spike encoder: an 8-bit intensity is integrated once per timestep
// and every accumulator overflow becomes a one-cycle spike on spike_out.
module spike_rate_encoder #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_value,
  output logic             in_ready,
  input  logic             step_en,
  input  logic             flush,
  output logic             spike_out,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] spike_count
);

  // state | meaning
  // IDLE  | no frame active; promotes the pending value when one is queued
  // RUN   | encoding cur_val, one accumulate per step_en
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam int                STEP_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_pend_val;
  logic              r_pend_v;
  logic [7:0]        r_cur_val;
  logic [7:0]        r_acc;
  logic [STEP_W-1:0] r_step_cnt;
  logic [CNT_W-1:0]  r_run_cnt;
  logic              r_spike_out;
  logic              r_frame_done;
  logic              r_busy;
  logic [CNT_W-1:0]  r_spike_count;

  logic [8:0]        w_sum;
  logic              w_step;
  logic              w_last;
  logic              w_load;
  logic              w_accept;

  // acc only keeps the residue below 256; the carry out is the spike
  assign w_sum = {1'b0, r_acc} + {1'b0, r_cur_val};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (r_pend_v) w_state_nxt = S_RUN;
        S_RUN:   if (w_last && !r_pend_v) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = !r_pend_v && !flush;
    w_accept = in_valid && in_ready;
    w_step   = (r_state == S_RUN) && step_en && !flush;
    w_last   = w_step && (r_step_cnt == LAST_STEP);
    w_load   = !flush && r_pend_v && ((r_state == S_IDLE) || w_last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_val    <= '0;
      r_pend_v      <= 1'b0;
      r_cur_val     <= '0;
      r_acc         <= '0;
      r_step_cnt    <= '0;
      r_run_cnt     <= '0;
      r_spike_out   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_spike_count <= '0;
    end else begin
      r_spike_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= (w_state_nxt == S_RUN);
      if (flush) begin
        r_pend_v   <= 1'b0;
        r_acc      <= '0;
        r_step_cnt <= '0;
        r_run_cnt  <= '0;
      end else begin
        if (w_accept) begin
          r_pend_val <= in_value;
          r_pend_v   <= 1'b1;
        end
        if (w_step) begin
          r_spike_out <= w_sum[8];
          r_acc       <= w_sum[7:0];
          r_step_cnt  <= r_step_cnt + STEP_W'(1);
          r_run_cnt   <= r_run_cnt + CNT_W'(w_sum[8]);
        end
        if (w_last) begin
          r_frame_done  <= 1'b1;
          r_spike_count <= r_run_cnt + CNT_W'(w_sum[8]);
        end
        // back-to-back frames: the queued value takes over on the last step
        if (w_load) begin
          r_cur_val  <= r_pend_val;
          r_pend_v   <= 1'b0;
          r_acc      <= '0;
          r_step_cnt <= '0;
          r_run_cnt  <= '0;
        end
      end
    end
  end

  assign spike_out   = r_spike_out;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  assign spike_count = r_spike_count;

endmodule
